// File: rtl/multicore_mem_pkg.sv
// Shared types and constants for the multicore memory arbiter.
package multicore_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  localparam int MEM_BYTES_DEFAULT = 1024;

  // Index width for N requesters, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/multicore_mem_arbiter_rr_pick.sv
// Combinational round-robin winner search starting just after the last grant.
module rr_pick
  import multicore_mem_pkg::*;
#(
  parameter int N   = 2,
  parameter int IDW = clog2_min1(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] last,
  output logic [IDW-1:0] winner,
  output logic           any
);

  logic found;

  // Cores above the pointer take priority, then the search wraps to core 0.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    any    = |req;
    for (int j = 0; j < N; j++) begin
      if (!found && req[j] && (j > int'(last))) begin
        found  = 1'b1;
        winner = IDW'(j);
      end
    end
    for (int j = 0; j < N; j++) begin
      if (!found && req[j] && (j <= int'(last))) begin
        found  = 1'b1;
        winner = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/multicore_mem_arbiter.sv
// Round-robin arbiter sharing one valid/ready memory port between N picorv32 cores.
module multicore_mem_arbiter
  import multicore_mem_pkg::*;
#(
  parameter int N         = 2,
  parameter int IDW       = clog2_min1(N),
  parameter int MEM_BYTES = MEM_BYTES_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N-1:0]       core_valid,
  input  logic [N-1:0]       core_instr,
  input  logic [N-1:0][31:0] core_addr,
  input  logic [N-1:0][31:0] core_wdata,
  input  logic [N-1:0][3:0]  core_wstrb,
  output logic [N-1:0]       core_ready,
  output logic [N-1:0][31:0] core_rdata,
  output logic               m_valid,
  output logic               m_instr,
  output logic [31:0]        m_addr,
  output logic [31:0]        m_wdata,
  output logic [3:0]         m_wstrb,
  input  logic               m_ready,
  input  logic [31:0]        m_rdata,
  output logic [IDW-1:0]     grant_id,
  output logic               busy
);

  localparam logic [IDW-1:0] LAST_RESET = IDW'(N - 1);
  localparam logic [31:0]    ADDR_LIMIT = 32'(MEM_BYTES);

  state_t         state;
  logic [IDW-1:0] last_grant;
  logic [IDW-1:0] pick;
  logic           pick_any;

  rr_pick #(
    .N   (N),
    .IDW (IDW)
  ) u_rr_pick (
    .req    (core_valid),
    .last   (last_grant),
    .winner (pick),
    .any    (pick_any)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= LAST_RESET;
      grant_id   <= '0;
      busy       <= 1'b0;
      m_valid    <= 1'b0;
      m_instr    <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
      m_wstrb    <= '0;
      core_ready <= '0;
      core_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            grant_id   <= pick;
            last_grant <= pick;
            busy       <= 1'b1;
            m_instr    <= core_instr[pick];
            m_addr     <= core_addr[pick];
            m_wdata    <= core_wdata[pick];
            m_wstrb    <= core_wstrb[pick];
            if (core_addr[pick] < ADDR_LIMIT) begin
              m_valid <= 1'b1;
              state   <= BUSY;
            end else begin
              // Outside the window: answer zero locally, the write is lost.
              core_rdata[pick] <= '0;
              state            <= RESP;
            end
          end
        end
        BUSY: begin
          if (m_ready) begin
            m_valid              <= 1'b0;
            core_rdata[grant_id] <= m_rdata;
            core_ready[grant_id] <= 1'b1;
            state                <= RESP;
          end
        end
        RESP: begin
          // Out-of-window grants arrive here without the pulse; issue it now.
          // Leaving through IDLE gives the served core a cycle to drop valid.
          if (|core_ready) begin
            core_ready <= '0;
            busy       <= 1'b0;
            state      <= IDLE;
          end else begin
            core_ready[grant_id] <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicore_mem_arbiter.sv
// Directed and randomized bench for multicore_mem_arbiter with a shared-memory reference model.
module tb_multicore_mem_arbiter;

  localparam int N    = 2;
  localparam int MEMB = 1024;

  logic               clk = 1'b0;
  logic               reset;
  logic [N-1:0]       cv, ci;
  logic [N-1:0][31:0] ca, cw;
  logic [N-1:0][3:0]  cs;
  logic [N-1:0]       core_ready;
  logic [N-1:0][31:0] core_rdata;
  logic               m_valid, m_instr;
  logic [31:0]        m_addr, m_wdata;
  logic [3:0]         m_wstrb;
  logic               m_ready;
  logic [31:0]        m_rdata;
  logic [0:0]         grant_id;
  logic               busy;

  int checks = 0;
  int errors = 0;
  int lat    = 1;

  always #5 clk = ~clk;

  multicore_mem_arbiter #(.N(N), .MEM_BYTES(MEMB)) dut (
    .clk        (clk),
    .reset      (reset),
    .core_valid (cv),
    .core_instr (ci),
    .core_addr  (ca),
    .core_wdata (cw),
    .core_wstrb (cs),
    .core_ready (core_ready),
    .core_rdata (core_rdata),
    .m_valid    (m_valid),
    .m_instr    (m_instr),
    .m_addr     (m_addr),
    .m_wdata    (m_wdata),
    .m_wstrb    (m_wstrb),
    .m_ready    (m_ready),
    .m_rdata    (m_rdata),
    .grant_id   (grant_id),
    .busy       (busy)
  );

  function automatic logic [31:0] init_word(input int i);
    return (i == 0) ? 32'h3fc00093 : (32'(i) * 32'h9e3779b1);
  endfunction

  // Downstream RAM: raises m_ready 'lat' cycles after it first sees m_valid.
  logic [31:0] mem [0:255];
  int          wcnt;
  always @(posedge clk) begin
    if (reset) begin
      m_ready <= 1'b0;
      m_rdata <= '0;
      wcnt    <= 0;
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
    end else if (m_valid && m_ready) begin
      m_ready <= 1'b0;
      wcnt    <= 0;
      for (int b = 0; b < 4; b++)
        if (m_wstrb[b]) mem[m_addr[9:2]][8*b +: 8] <= m_wdata[8*b +: 8];
    end else if (m_valid) begin
      if (wcnt >= lat - 1) begin
        m_ready <= 1'b1;
        m_rdata <= mem[m_addr[9:2]];
      end else begin
        wcnt <= wcnt + 1;
      end
    end else begin
      m_ready <= 1'b0;
      wcnt    <= 0;
    end
  end

  // Reference model state
  logic [31:0]        ref_mem [0:255];
  logic [N-1:0][31:0] exp_rd;
  int                 model_last;
  int                 served [N];
  logic [N-1:0]       mhist [0:4095];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_read(input logic [31:0] addr);
    return (addr < MEMB) ? ref_mem[addr[9:2]] : 32'h0;
  endfunction

  task automatic ref_apply(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb);
    if (addr < MEMB)
      for (int b = 0; b < 4; b++)
        if (wstrb[b]) ref_mem[addr[9:2]][8*b +: 8] = wdata[8*b +: 8];
  endtask

  function automatic int rr_ref(input logic [N-1:0] m, input int last);
    for (int s = 1; s <= N; s++) begin
      int c;
      c = (last + s) % N;
      if (m[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    model_last = N - 1;
    exp_rd     = '0;
    for (int i = 0; i < N; i++) served[i] = 0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_m_valid"}, 32'(m_valid), 32'd0);
    chk({tag, "_m_instr"}, 32'(m_instr), 32'd0);
    chk({tag, "_m_addr"}, m_addr, 32'd0);
    chk({tag, "_m_wdata"}, m_wdata, 32'd0);
    chk({tag, "_m_wstrb"}, 32'(m_wstrb), 32'd0);
    chk({tag, "_core_ready"}, 32'(core_ready), 32'd0);
    chk({tag, "_rdata0"}, core_rdata[0], 32'd0);
    chk({tag, "_rdata1"}, core_rdata[1], 32'd0);
    chk({tag, "_grant_id"}, 32'(grant_id), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cv = '0; ci = '0; ca = '0; cw = '0; cs = '0;
    repeat (2) tick();
    chk_reset_outputs("reset");
    model_reset();
    reset = 1'b0;
  endtask

  task automatic new_req(input int j, input bit oor_ok);
    cv[j] = 1'b1;
    ci[j] = 1'($urandom_range(0, 1));
    cw[j] = $urandom;
    cs[j] = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'h0;
    if (oor_ok && $urandom_range(0, 4) == 0) ca[j] = 32'h400 + 32'($urandom_range(0, 255)) * 4;
    else                                     ca[j] = 32'($urandom_range(0, 15)) * 4;
  endtask

  // Cores issue random accesses; each completion is checked against the
  // round-robin rule applied to the request mask seen at its arbitration edge.
  task automatic serve_loop(input int ntx, input bit cont, input bit oor_ok);
    int done, cyc, since, last_rdy, i, arb, expw;
    int idle_cnt [N];
    logic [31:0] exp;
    done = 0; cyc = 0; since = 0; last_rdy = -1;
    for (int j = 0; j < N; j++) idle_cnt[j] = 0;
    mhist[0] = cv;
    mhist[1] = cv;
    while (done < ntx || cv != '0) begin
      tick();
      cyc++;
      since++;
      if (m_valid) chk("m_valid_in_window", 32'(m_addr < MEMB), 32'd1);
      if (core_ready != '0) begin
        i = 0;
        for (int j = N - 1; j >= 0; j--) if (core_ready[j]) i = j;
        chk("ready_onehot", 32'($countones(core_ready)), 32'd1);
        arb  = cyc - ((ca[i] < MEMB) ? lat + 1 : 1);
        expw = (arb >= 0) ? rr_ref(mhist[arb], model_last) : -1;
        chk("rr_winner", 32'(i), 32'(expw));
        chk("grant_id", 32'(grant_id), 32'(i));
        exp = ref_read(ca[i]);
        chk("rdata", core_rdata[i], exp);
        exp_rd[i] = exp;
        if (ca[i] < MEMB) begin
          chk("m_addr_fields", m_addr, ca[i]);
          chk("m_wdata_fields", m_wdata, cw[i]);
          chk("m_wstrb_fields", 32'(m_wstrb), 32'(cs[i]));
          chk("m_instr_fields", 32'(m_instr), 32'(ci[i]));
          ref_apply(ca[i], cw[i], cs[i]);
        end
        for (int j = 0; j < N; j++)
          if (j != i) chk("rdata_hold", core_rdata[j], exp_rd[j]);
        if (cont && last_rdy >= 0) chk("spacing", 32'(cyc - last_rdy), 32'd4);
        last_rdy   = cyc;
        since      = 0;
        model_last = i;
        served[i]++;
        done++;
        cv[i]       = 1'b0;
        idle_cnt[i] = cont ? 0 : $urandom_range(0, 3);
      end
      for (int j = 0; j < N; j++) begin
        if (!cv[j]) begin
          if (idle_cnt[j] > 0) idle_cnt[j]--;
          else if (done + $countones(cv) < ntx) new_req(j, oor_ok);
        end
      end
      if (since > 60) begin
        chk("serve_timeout", 32'(since), 32'd0);
        cv = '0;
        break;
      end
      if (cyc + 1 < 4096) mhist[cyc + 1] = cv;
    end
    repeat (2) tick();
  endtask

  // One isolated access by core c; exp_lat counts edges from request to visible ready.
  task automatic single(input int c, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, input int exp_lat, output logic [31:0] got);
    int n;
    bit saw_mv;
    logic [31:0] exp;
    cv[c] = 1'b1; ci[c] = 1'b0; ca[c] = addr; cw[c] = wdata; cs[c] = wstrb;
    n = 0; saw_mv = 1'b0;
    do begin
      tick();
      n++;
      if (m_valid) saw_mv = 1'b1;
    end while (core_ready == '0 && n < 30);
    chk("single_latency", 32'(n), 32'(exp_lat));
    chk("single_ready_mask", 32'(core_ready), 32'(1) << c);
    chk("single_m_valid_seen", 32'(saw_mv), 32'(addr < MEMB));
    exp = ref_read(addr);
    chk("single_rdata", core_rdata[c], exp);
    got       = core_rdata[c];
    exp_rd[c] = exp;
    ref_apply(addr, wdata, wstrb);
    model_last = c;
    cv[c] = 1'b0;
    tick();
    chk("single_ready_drop", 32'(core_ready), 32'd0);
  endtask

  initial begin
    logic [31:0] got;
    int n;
    do_reset();

    // Single read of word 0 with a one-cycle memory
    lat = 1;
    cv[0] = 1'b1; ci[0] = 1'b1; ca[0] = 32'h0; cw[0] = 32'h0; cs[0] = 4'h0;
    tick();
    chk("t1_m_valid_t1", 32'(m_valid), 32'd1);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_grant", 32'(grant_id), 32'd0);
    chk("t1_m_addr", m_addr, 32'h0);
    chk("t1_m_instr", 32'(m_instr), 32'd1);
    chk("t1_ready_t1", 32'(core_ready), 32'd0);
    tick();
    chk("t1_m_valid_t2", 32'(m_valid), 32'd1);
    chk("t1_ready_t2", 32'(core_ready), 32'd0);
    tick();
    chk("t1_ready_t3", 32'(core_ready), 32'b01);
    chk("t1_rdata", core_rdata[0], 32'h3fc00093);
    chk("t1_m_valid_drop", 32'(m_valid), 32'd0);
    cv[0] = 1'b0; exp_rd[0] = 32'h3fc00093; model_last = 0;
    tick();
    chk("t1_ready_clear", 32'(core_ready), 32'd0);
    chk("t1_busy_clear", 32'(busy), 32'd0);

    // Both cores requesting back to back from reset
    do_reset();
    new_req(0, 1'b0);
    new_req(1, 1'b0);
    serve_loop(100, 1'b1, 1'b0);
    chk("fair_core0", 32'(served[0]), 32'd50);
    chk("fair_core1", 32'(served[1]), 32'd50);

    // Write by core 1 seen by core 0 through the shared memory
    single(1, 32'h3fc, 32'h0000_0004, 4'b1111, 3, got);
    single(0, 32'h3fc, 32'h0, 4'h0, 3, got);
    chk("shared_mem_value", got, 32'h0000_0004);

    // Out-of-window access
    single(0, 32'h400, 32'h1234_5678, 4'b1111, 2, got);
    chk("oor_rdata", got, 32'h0);

    // Slow memory: request fields must stay put while waiting
    lat = 5;
    cv[0] = 1'b1; ci[0] = 1'b0; ca[0] = 32'h10; cw[0] = 32'ha5a5_5a5a; cs[0] = 4'b0101;
    tick();
    chk("slow_m_valid_first", 32'(m_valid), 32'd1);
    n = 0;
    while (core_ready == '0 && n < 20) begin
      tick();
      if (core_ready == '0) begin
        n++;
        chk("slow_m_addr", m_addr, ca[0]);
        chk("slow_m_wdata", m_wdata, cw[0]);
        chk("slow_m_wstrb", 32'(m_wstrb), 32'(cs[0]));
        chk("slow_busy", 32'(busy), 32'd1);
        chk("slow_m_valid", 32'(m_valid), 32'd1);
      end
    end
    chk("slow_wait_cycles", 32'(n), 32'd5);
    chk("slow_ready", 32'(core_ready), 32'b01);
    chk("slow_rdata", core_rdata[0], ref_read(32'h10));
    exp_rd[0] = ref_read(32'h10);
    ref_apply(32'h10, 32'ha5a5_5a5a, 4'b0101);
    model_last = 0;
    cv[0] = 1'b0;
    tick();
    single(0, 32'h10, 32'h0, 4'h0, 7, got);

    // Random mix with idle gaps and out-of-window accesses
    lat = 2;
    serve_loop(60, 1'b0, 1'b1);

    // Reset in the middle of a downstream access
    lat = 5;
    cv[1] = 1'b1; ci[1] = 1'b0; ca[1] = 32'h20; cw[1] = 32'h0; cs[1] = 4'h0;
    tick();
    tick();
    chk("rst_busy_before", 32'(m_valid), 32'd1);
    reset = 1'b1;
    tick();
    chk_reset_outputs("midrst");
    reset = 1'b0;
    model_reset();
    new_req(0, 1'b0);
    new_req(1, 1'b0);
    tick();
    chk("postrst_grant", 32'(grant_id), 32'd0);
    chk("postrst_m_valid", 32'(m_valid), 32'd1);
    chk("postrst_m_addr", m_addr, ca[0]);
    serve_loop(6, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "global timeout");
  end

endmodule
